// File: rtl/stack_ctrl_if.sv
// stack_ctrl_if: request/response bundle between a stack requester and
// stack_ctrl, and from stack_ctrl on to the stack memory.
//   Push, Pop, Clear        : requests (requester -> controller)
//   PushEnbl, PopEnbl       : combinational memory enables
//   TOS, Count              : registered pointer / occupancy
//   Stack_Full/Empty/Error  : registered state flags
interface stack_ctrl_if #(parameter int ADDR_W = 3);
  logic              Push;
  logic              Pop;
  logic              Clear;
  logic              PushEnbl;
  logic              PopEnbl;
  logic [ADDR_W-1:0] TOS;
  logic              Stack_Full;
  logic              Stack_Empty;
  logic              Stack_Error;
  logic [ADDR_W:0]   Count;

  modport master (
    output Push, Pop, Clear,
    input  PushEnbl, PopEnbl, TOS, Stack_Full, Stack_Empty, Stack_Error, Count
  );

  modport slave (
    input  Push, Pop, Clear,
    output PushEnbl, PopEnbl, TOS, Stack_Full, Stack_Empty, Stack_Error, Count
  );
endinterface

// File: rtl/stack_ctrl.sv
// stack_ctrl: control stage ahead of the stack memory. Turns raw push/pop
// requests into memory enables, a top-of-stack address and state flags,
// rejecting push-when-full and pop-when-empty with a sticky error state.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : stack_ctrl_if.slave (requests in, enables/TOS/flags/Count out)
// Address convention: TOS = Count while not full, DEPTH-1 when full. The
// memory writes at TOS and reads at (Stack_Full ? TOS : TOS-1).
module stack_ctrl #(
  parameter int ADDR_W = 3
) (
  input  logic         clk,
  input  logic         rst,
  stack_ctrl_if.slave  bus
);

  localparam logic [ADDR_W:0] DEPTH_C  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LAST_CNT = DEPTH_C - 1'b1;
  localparam logic [ADDR_W:0] ONE_CNT  = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {EMPTY, NORMAL, FULL, ERROR} state_t;

  state_t state, nxt;

  // Simultaneous Push+Pop is a no-op, so only exclusive requests count.
  logic push_req, pop_req;
  assign push_req = bus.Push & ~bus.Pop;
  assign pop_req  = bus.Pop  & ~bus.Push;

  // Enables are a same-cycle decode; rst drops them immediately.
  always_comb begin
    bus.PushEnbl = ~rst & ~bus.Clear & push_req &
                   ((state == EMPTY) | (state == NORMAL));
    bus.PopEnbl  = ~rst & ~bus.Clear & pop_req &
                   ((state == NORMAL) | (state == FULL));
  end

  always_comb begin
    nxt = state;
    if (bus.Clear) begin
      nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push_req)     nxt = (bus.Count == LAST_CNT) ? FULL : NORMAL;
          else if (pop_req) nxt = ERROR;
        end
        NORMAL: begin
          if (push_req)     nxt = (bus.Count == LAST_CNT) ? FULL : NORMAL;
          else if (pop_req) nxt = (bus.Count == ONE_CNT) ? EMPTY : NORMAL;
        end
        FULL: begin
          if (push_req)     nxt = ERROR;
          else if (pop_req) nxt = NORMAL;
        end
        default: nxt = ERROR;   // ERROR is left only via Clear or rst
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= EMPTY;
      bus.TOS         <= '0;
      bus.Count       <= '0;
      bus.Stack_Full  <= 1'b0;
      bus.Stack_Empty <= 1'b1;
      bus.Stack_Error <= 1'b0;
    end else begin
      state           <= nxt;
      bus.Stack_Full  <= (nxt == FULL);
      bus.Stack_Empty <= (nxt == EMPTY);
      bus.Stack_Error <= (nxt == ERROR);
      if (bus.Clear) begin
        bus.TOS   <= '0;
        bus.Count <= '0;
      end else if (bus.PushEnbl) begin
        bus.Count <= bus.Count + 1'b1;
        // The push that fills the stack leaves TOS on the last written slot.
        if (nxt != FULL) bus.TOS <= bus.TOS + 1'b1;
      end else if (bus.PopEnbl) begin
        bus.Count <= bus.Count - 1'b1;
        // Popping from FULL read slot TOS itself, which is now the next free slot.
        if (state != FULL) bus.TOS <= bus.TOS - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
module tb_stack_ctrl;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stack_ctrl_if #(.ADDR_W(AW)) bus ();
  stack_ctrl #(.ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] pe;
    logic [31:0] qe;
    logic [31:0] tos;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: occupancy plus sticky error.
  int m_cnt = 0;
  bit m_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int m_tos();
    return (m_cnt == DEPTH) ? DEPTH - 1 : m_cnt;
  endfunction

  task automatic check_regs(input string tag);
    chk({tag, ".Count"}, bus.Count, m_cnt);
    chk({tag, ".TOS"}, bus.TOS, m_tos());
    chk({tag, ".Full"}, bus.Stack_Full, (!m_err && m_cnt == DEPTH));
    chk({tag, ".Empty"}, bus.Stack_Empty, (!m_err && m_cnt == 0));
    chk({tag, ".Error"}, bus.Stack_Error, m_err);
  endtask

  // One clock of stimulus: drive mid-low-phase, score the combinational
  // enables against the pre-edge TOS, then check registered state after the edge.
  task automatic cyc(input bit p, input bit q, input bit c, input string tag);
    exp_t e, got;
    bit pe, qe;
    @(negedge clk);
    bus.Push = p; bus.Pop = q; bus.Clear = c;
    pe = p && !q && !c && !m_err && m_cnt < DEPTH;
    qe = q && !p && !c && !m_err && m_cnt > 0;
    e.pe = pe; e.qe = qe; e.tos = m_tos();
    exp_q.push_back(e);
    #1;
    got = exp_q.pop_front();
    chk({tag, ".PushEnbl"}, bus.PushEnbl, got.pe);
    chk({tag, ".PopEnbl"}, bus.PopEnbl, got.qe);
    if (got.pe || got.qe) chk({tag, ".TOS@en"}, bus.TOS, got.tos);
    @(posedge clk);
    if (c) begin m_cnt = 0; m_err = 0; end
    else if (m_err) ;
    else if (pe) m_cnt++;
    else if (qe) m_cnt--;
    else if (p != q) m_err = 1;
    #1;
    check_regs(tag);
  endtask

  initial begin
    bus.Push = 0; bus.Pop = 0; bus.Clear = 0;
    repeat (2) @(posedge clk);
    #1;
    check_regs("reset");
    chk("reset.PushEnbl", bus.PushEnbl, 0);
    @(negedge clk);
    rst = 0;

    repeat (3) cyc(0, 0, 0, "idle");
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, "push_fill");
    for (int i = 0; i < DEPTH; i++) cyc(0, 1, 0, "pop_drain");
    cyc(0, 1, 0, "pop_empty_err");
    cyc(1, 0, 0, "push_in_err");
    cyc(0, 1, 0, "pop_in_err");
    cyc(0, 0, 1, "clear_err");

    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, "push_fill2");
    cyc(1, 0, 0, "push_full_err");
    cyc(0, 0, 1, "clear2");
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, "push3");
    cyc(1, 1, 0, "push_pop_nop");
    cyc(1, 0, 1, "clear_with_push");
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, "push5");

    // Asynchronous reset mid-cycle while a push is being requested.
    @(negedge clk);
    bus.Push = 1; bus.Pop = 0; bus.Clear = 0;
    #1;
    chk("pre_rst.PushEnbl", bus.PushEnbl, 1);
    chk("pre_rst.TOS", bus.TOS, 5);
    rst = 1;
    #1;
    m_cnt = 0; m_err = 0;
    check_regs("async_rst");
    chk("async_rst.PushEnbl", bus.PushEnbl, 0);
    chk("async_rst.PopEnbl", bus.PopEnbl, 0);
    bus.Push = 0;
    #1;
    rst = 0;
    cyc(1, 0, 0, "push_after_rst");

    // Random mix; rare clears keep it out of the error state most of the time.
    for (int i = 0; i < 120; i++) begin
      bit p, q, c;
      p = $urandom_range(0, 1);
      q = $urandom_range(0, 1);
      c = ($urandom_range(0, 15) == 0);
      cyc(p, q, c, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Control stage directly upstream of the stack memory. It converts raw push/pop requests into the memory's write/read enables, top-of-stack address and full flag. It tracks occupancy with a four-state FSM and blocks illegal operations: push when full, pop when empty. Its outputs connect one-to-one to the memory's PushEnbl, PopEnbl, Stack_Full and TOS inputs.

## Interface
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries (8 by default)
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- Push  input  1  push request, sampled each cycle
- Pop  input  1  pop request, sampled each cycle
- Clear  input  1  synchronous clear; highest priority after rst
- PushEnbl  output  1  write enable to memory (combinational)
- PopEnbl  output  1  read enable to memory (combinational)
- TOS  output  ADDR_W  stack address to memory (registered)
- Stack_Full  output  1  stack holds DEPTH entries (registered)
- Stack_Empty  output  1  stack holds 0 entries (registered)
- Stack_Error  output  1  sticky illegal-operation flag (registered)
- Count  output  ADDR_W+1  occupancy, 0..DEPTH (registered)

## Operation
- Address convention, which must match the memory:
  - When not full, TOS = next free slot = Count.
  - When full, TOS = DEPTH-1, the last written slot.
  - The memory writes at TOS and reads at Stack_Full ? TOS : TOS-1.
- FSM states: EMPTY, NORMAL, FULL, ERROR.
- Legal push: Push=1, Pop=0, Clear=0, state in {EMPTY, NORMAL}.
  - Asserts PushEnbl.
  - Next cycle: Count+1.
  - If Count becomes DEPTH: state FULL and TOS holds DEPTH-1. Otherwise TOS+1 and state NORMAL.
- Legal pop: Pop=1, Push=0, Clear=0, state in {NORMAL, FULL}.
  - Asserts PopEnbl.
  - From FULL: TOS stays DEPTH-1, Count becomes DEPTH-1, state NORMAL.
  - From NORMAL: TOS-1 and Count-1. State EMPTY if Count becomes 0.
- Push and Pop both 1: no-op. No enables, no state change, no error.
- Push in FULL, or Pop in EMPTY (other request 0):
  - No enable asserted.
  - Next state ERROR; Stack_Error=1.
  - TOS and Count are frozen.
- ERROR:
  - All requests are ignored and both enables are forced to 0.
  - Exit only via Clear or rst.
- Clear=1, any state: enables 0. Next cycle TOS=0, Count=0, state EMPTY, Stack_Error=0.
- Flags are decoded from state and registered with it:
  - Stack_Full = (state==FULL).
  - Stack_Empty = (state==EMPTY).
  - Stack_Error = (state==ERROR).
- TOS arithmetic is modulo 2**ADDR_W. By the rules above it never actually wraps. Count is ADDR_W+1 bits so that DEPTH is representable.

## Timing
- Reset values: TOS=0, Count=0, Stack_Empty=1, Stack_Full=0, Stack_Error=0, state EMPTY.
- PushEnbl and PopEnbl are 0 while rst=1.
- Enables are a combinational decode of the current registered state plus Push/Pop/Clear. They are valid in the same cycle as the request.
- The memory samples enables and TOS on the same rising edge at which this block updates TOS. The memory therefore always sees the pre-update address: zero-cycle request-to-enable, one-cycle enable-to-pointer update.
- Back-to-back push or pop every cycle is supported at full rate. Flags reflect the result one cycle after the edge.
- rst asserted mid-operation clears all state immediately, asynchronously. An in-flight enable is dropped at that instant.
- Request inputs must be synchronous to clk. There is no internal synchronizer.

## Test plan
- Reset, then idle 3 cycles -> TOS=0, Count=0, Stack_Empty=1, Stack_Full=0, Stack_Error=0, both enables 0.
- 8 consecutive pushes:
  - PushEnbl=1 each cycle, with TOS presented as 0,1,...,7.
  - After the 8th: Stack_Full=1, TOS=7, Count=8, Stack_Empty=0.
- From full, 8 consecutive pops:
  - First pop: PopEnbl=1, TOS=7, Stack_Full=1, so the memory reads slot 7. Next cycle TOS=7, Count=7, Stack_Full=0.
  - Remaining pops present TOS 7,6,...,1.
  - End state: TOS=0, Count=0, Stack_Empty=1.
- Pop on empty -> PopEnbl=0, Stack_Error=1 next cycle. A subsequent legal Push gives PushEnbl=0 and Count stays 0. Clear returns Stack_Error=0, state EMPTY.
- Push at Count=8 -> PushEnbl=0, Stack_Error=1, TOS stays 7, Count stays 8. Simultaneous Push+Pop at Count=3 -> no enables, TOS=3, Count=3, no error.
- rst pulsed asynchronously (mid-cycle) at Count=5 -> outputs return to reset values before the next clock edge. A push after release writes at TOS=0.
